// File: rtl/spi_flash_rd_ctrl.sv
// SPI mode-0 flash read master: one 32-bit word per request via READ (0x03) + 24-bit address.
// Define SPI_FLASH_FAST_READ_EN to issue FAST_READ (0x0B) with 8 dummy SCK periods instead.
module spi_flash_rd_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int ADDR_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] CMD    = 8'h0B;
    localparam int         N_BITS = 72;
`else
    localparam logic [7:0] CMD    = 8'h03;
    localparam int         N_BITS = 64;
`endif

    localparam int               DIV_W      = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] PHASE_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST   = DIV_W'(CLK_DIV);
    localparam logic [6:0]       BIT_LAST   = 7'(N_BITS - 1);
    localparam logic [6:0]       RX_FIRST   = 7'(N_BITS - 32);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [6:0]       bit_cnt;
    logic [31:0]      tx_shift;
    logic [31:0]      rx_shift;
    logic             phase_done;
    logic             gap_done;

    assign phase_done = (div_cnt == PHASE_LAST);
    // GAP also covers the response cycle, so it runs one cycle longer than a phase.
    assign gap_done   = (div_cnt == GAP_LAST);
    assign req_ready  = rst_n && (state == IDLE);
    assign spi_mosi   = tx_shift[31];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_valid) state_nxt = SETUP;
            SETUP:   if (phase_done) state_nxt = SHIFT;
            SHIFT:   if (spi_sck && phase_done && bit_cnt == BIT_LAST) state_nxt = HOLD;
            HOLD:    if (phase_done) state_nxt = GAP;
            GAP:     if (gap_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: rx_shift has no reset; it is fully refilled before rsp_data ever reads it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            spi_cs_n  <= 1'b1;
            spi_sck   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            div_cnt   <= div_cnt + DIV_W'(1);
            unique case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (req_valid) begin
                        tx_shift <= {CMD, req_addr};
                        spi_cs_n <= 1'b0;
                    end
                end
                SETUP: begin
                    if (phase_done) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (phase_done) begin
                        div_cnt <= '0;
                        spi_sck <= ~spi_sck;
                        if (!spi_sck) begin
                            if (bit_cnt >= RX_FIRST) rx_shift <= {rx_shift[30:0], spi_miso};
                        end else begin
                            // Zeros shift in behind the command/address, so MOSI idles low afterwards.
                            tx_shift <= {tx_shift[30:0], 1'b0};
                            if (bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + 7'd1;
                        end
                    end
                end
                HOLD: begin
                    if (phase_done) begin
                        div_cnt   <= '0;
                        spi_cs_n  <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= {rx_shift[7:0], rx_shift[15:8], rx_shift[23:16], rx_shift[31:24]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Self-checking bench for spi_flash_rd_ctrl: flash model, cycle-level timeline model, directed and random requests.
// Build with SPI_FLASH_FAST_READ_EN defined to exercise the FAST_READ variant.
`timescale 1ns/1ps
module tb_spi_flash_rd_ctrl;
    localparam int D = 2;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] CMD         = 8'h0B;
    localparam int         N_BITS      = 72;
    localparam int         LAT_LIT     = 293;
    localparam int         SPACING_LIT = 296;
`else
    localparam logic [7:0] CMD         = 8'h03;
    localparam int         N_BITS      = 64;
    localparam int         LAT_LIT     = 261;
    localparam int         SPACING_LIT = 264;
`endif
    localparam int OUT_START = N_BITS - 32;
    localparam int LAT       = 1 + (2 + 2 * N_BITS) * D;
    localparam int SHIFT_END = D + 2 * N_BITS * D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    spi_flash_rd_ctrl #(.CLK_DIV(D), .ADDR_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            24'h000104: return 8'h55;
            default:    return (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ 8'h5C;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        logic [23:0] a1, a2, a3;
        a1 = a + 24'd1;
        a2 = a + 24'd2;
        a3 = a + 24'd3;
        return {mem_byte(a3), mem_byte(a2), mem_byte(a1), mem_byte(a)};
    endfunction

    // Serial flash model: decodes command/address on SCK rise, drives data on SCK fall.
    logic [7:0]  f_cmd = '0, last_cmd = '0;
    logic [23:0] f_addr = '0, last_addr = '0;
    logic [23:0] f_ba;
    logic [7:0]  f_byte;
    int          f_cnt = 0, f_rises = 0, last_rises = 0, f_k;

    always @(negedge spi_cs_n) begin
        f_cnt   = 0;
        f_rises = 0;
    end

    always @(posedge spi_cs_n) begin
        last_cmd   = f_cmd;
        last_addr  = f_addr;
        last_rises = f_rises;
        f_cnt      = 0;
    end

    always @(posedge spi_sck) begin
        if (!spi_cs_n) begin
            if (f_cnt < 8)       f_cmd  = {f_cmd[6:0], spi_mosi};
            else if (f_cnt < 32) f_addr = {f_addr[22:0], spi_mosi};
            f_cnt++;
            f_rises++;
        end
    end

    always @(negedge spi_sck) begin
        if (!spi_cs_n) begin
            if (f_cnt >= OUT_START) begin
                f_k      = f_cnt - OUT_START;
                f_ba     = f_addr + 24'(f_k / 8);
                f_byte   = mem_byte(f_ba);
                spi_miso = f_byte[7 - (f_k % 8)];
            end else begin
                spi_miso = 1'($urandom);
            end
        end
    end

    // Timeline model: position within the current transaction, counted in clk cycles since accept.
    bit          m_busy = 1'b0;
    int          m_t = 0;
    logic [23:0] m_addr = '0;
    logic [31:0] m_rsp = '0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_t    = 0;
            m_rsp  = '0;
            chk_en = 1'b1;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1'b1;
                m_t    = 1;
                m_addr = req_addr;
            end
        end else begin
            m_t++;
            if (m_t == LAT) m_rsp = exp_word(m_addr);
            if (m_t > LAT + D) m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin : cmp
        logic        e_cs, e_sck, e_mosi, e_rv;
        logic [31:0] w;
        int          u, k;
        if (chk_en) begin
            e_cs = 1'b1; e_sck = 1'b0; e_mosi = 1'b0; e_rv = 1'b0;
            w = {CMD, m_addr};
            if (m_busy) begin
                if (m_t <= D) begin
                    e_cs   = 1'b0;
                    e_mosi = w[31];
                end else if (m_t <= SHIFT_END) begin
                    u      = m_t - D - 1;
                    k      = u / (2 * D);
                    e_cs   = 1'b0;
                    e_sck  = ((u % (2 * D)) >= D);
                    e_mosi = (k < 32) ? w[31 - k] : 1'b0;
                end else if (m_t <= SHIFT_END + D) begin
                    e_cs = 1'b0;
                end else if (m_t == LAT) begin
                    e_rv = 1'b1;
                end
            end
            check("req_ready", 32'(req_ready), 32'(rst_n && !m_busy));
            check("spi_cs_n",  32'(spi_cs_n),  32'(e_cs));
            check("spi_sck",   32'(spi_sck),   32'(e_sck));
            check("spi_mosi",  32'(spi_mosi),  32'(e_mosi));
            check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            check("rsp_data",  rsp_data,       m_rsp);
        end
    end

    // Event recorders for the directed latency / spacing checks.
    int          acc_cyc[$];
    int          rsp_cyc[$];
    logic [31:0] rsp_dat[$];
    int          cs_runs[$];
    int          cs_run = 0;

    always @(negedge clk) begin
        if (rst_n && req_valid && req_ready) acc_cyc.push_back(cyc);
        if (rsp_valid) begin
            rsp_cyc.push_back(cyc);
            rsp_dat.push_back(rsp_data);
        end
        if (spi_cs_n === 1'b1) cs_run++;
        else begin
            if (cs_run > 0) cs_runs.push_back(cs_run);
            cs_run = 0;
        end
    end

    task automatic clear_logs();
        acc_cyc.delete();
        rsp_cyc.delete();
        rsp_dat.delete();
        cs_runs.delete();
    endtask

    task automatic wait_ready(output bit got);
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [23:0] a);
        bit got;
        @(posedge clk); #2;
        req_valid = 1'b1;
        req_addr  = a;
        wait_ready(got);
        @(posedge clk); #2;
        req_valid = 1'b0;
        req_addr  = 24'($urandom);
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 4 * SPACING_LIT && rsp_cyc.size() < n; i++) @(negedge clk);
        check("rsp_count", 32'(rsp_cyc.size()), 32'(n));
    endtask

    task automatic single_read(input logic [23:0] a, input logic [31:0] exp_lit);
        clear_logs();
        issue(a);
        wait_rsp(1);
        if (rsp_cyc.size() == 1 && acc_cyc.size() == 1) begin
            check("latency", 32'(rsp_cyc[0] - acc_cyc[0]), 32'(LAT_LIT));
            check("word", rsp_dat[0], exp_lit);
        end
        check("flash_cmd", 32'(last_cmd), 32'(CMD));
        check("flash_addr", 32'(last_addr), 32'(a));
        check("sck_rises", 32'(last_rises), 32'(N_BITS));
    endtask

    initial begin
        bit got;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);
        check("cs_n_after_reset", 32'(spi_cs_n), 32'd1);

        single_read(24'h000100, 32'h44332211);
        single_read(24'h000101, 32'h55443322);
        single_read(24'hFFFFFE, exp_word(24'hFFFFFE));

        // Back-to-back with req_valid held high.
        clear_logs();
        @(posedge clk); #2;
        req_valid = 1'b1;
        req_addr  = 24'h000000;
        for (int i = 0; i < 3; i++) begin
            wait_ready(got);
            @(posedge clk); #2;
            if (i < 2) req_addr = 24'(4 * (i + 1));
            else req_valid = 1'b0;
        end
        wait_rsp(3);
        if (acc_cyc.size() == 3 && rsp_cyc.size() == 3) begin
            for (int i = 1; i < 3; i++) begin
                check("b2b_accept_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(SPACING_LIT));
                check("b2b_rsp_spacing", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'(SPACING_LIT));
            end
            for (int i = 0; i < 3; i++) check("b2b_word", rsp_dat[i], exp_word(24'(4 * i)));
        end
        check("b2b_cs_gap_count", 32'(cs_runs.size()), 32'd3);
        if (cs_runs.size() == 3) begin
            check("b2b_cs_gap1", 32'(cs_runs[1]), 32'(D + 2));
            check("b2b_cs_gap2", 32'(cs_runs[2]), 32'(D + 2));
        end

        // Reset while shifting bit 40.
        clear_logs();
        issue(24'h000200);
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (m_busy && m_t == D + 1 + 40 * 2 * D) begin
                got = 1'b1;
                break;
            end
        end
        check("reached_bit40", 32'(got), 32'd1);
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_cs_n", 32'(spi_cs_n), 32'd1);
        check("abort_sck", 32'(spi_sck), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (LAT_LIT + 20) @(negedge clk);
        check("abort_no_rsp", 32'(rsp_cyc.size()), 32'd0);
        single_read(24'h000100, 32'h44332211);

        // Random requests, addresses and occasional resets, checked by the timeline model.
        for (int c = 0; c < 12000; c++) begin
            @(posedge clk); #2;
            req_valid = ($urandom_range(0, 3) == 0);
            req_addr  = 24'($urandom);
            rst_n     = ($urandom_range(0, 1499) != 0);
        end
        @(posedge clk); #2;
        req_valid = 1'b0;
        rst_n     = 1'b1;
        repeat (2 * SPACING_LIT) @(negedge clk);
        check("drained_idle", 32'(req_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_flash_rd_ctrl.md
Name: spi_flash_rd_ctrl

Overview:
SPI master that turns single-word read requests into serial-flash READ transactions (cmd 0x03, 24-bit address, 4 data bytes) and returns one 32-bit word per request.
Sits between the FPGA top's boot/XIP bus adapter and the external SPI flash pins (spi_cs_n/spi_sck/spi_mosi/spi_miso), which go to the board flash or to the simulation flash model.
SPI mode 0, MSB-first, one transaction in flight.

Parameters:
CLK_DIV, 2, SCK half-period in clk cycles; legal range >=1. CLK_DIV=1 gives SCK = clk/2.
ADDR_W, 24, flash byte-address width; only 24 is supported.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous, active-low
req_valid  input  1  read request valid
req_ready  output  1  request accepted when req_valid && req_ready at posedge
req_addr  input  24  flash byte address; no alignment required
rsp_valid  output  1  one-cycle pulse; rsp_data valid; no backpressure
rsp_data  output  32  read word; first received byte in [7:0], fourth in [31:24]
spi_cs_n  output  1  flash chip select, active-low
spi_sck  output  1  SPI clock, idle low
spi_mosi  output  1  master out
spi_miso  input  1  master in

Behaviour:
- Reset values: req_ready=0 during reset and 1 on the first cycle out of reset; rsp_valid=0; rsp_data=0; spi_cs_n=1; spi_sck=0; spi_mosi=0.
- Reset asserted mid-transaction: on the next posedge, spi_cs_n=1 and spi_sck=0. The transaction is abandoned. No rsp_valid.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - req_ready=1.
  - On accept (cycle 0), latch {8'h03, req_addr} into a 32-bit shift register and go to SETUP.
  - req_ready=0 in every other state.
- SETUP:
  - spi_cs_n=0 from cycle 1.
  - spi_mosi = bit 31 of the shift register.
  - spi_sck stays low for CLK_DIV cycles.
- SHIFT:
  - Exactly N_BITS SCK periods. N_BITS=64 by default: 32 out, 32 in.
  - Each period is CLK_DIV cycles low followed by CLK_DIV cycles high.
  - miso is sampled on the clk edge that raises spi_sck.
  - mosi updates on the clk edge that lowers spi_sck.
  - Bit counter is 7 bits, counting 0..N_BITS-1.
  - After the 32 out-bits, spi_mosi=0.
  - Received bits are MSB-first within each byte and assembled into rsp_data byte lanes in arrival order.
- HOLD: spi_sck=0, spi_cs_n=0 for CLK_DIV cycles.
- End of HOLD:
  - spi_cs_n=1.
  - rsp_valid=1 for exactly one cycle, with rsp_data updated in that same cycle.
  - rsp_data holds its value until the next response.
- GAP:
  - spi_cs_n high for CLK_DIV cycles; this is the minimum deselect time.
  - Then IDLE with req_ready=1.
  - A req_valid held high continuously is accepted on the first IDLE cycle.
- Latency, accept to rsp_valid: 1 + (2 + 2*N_BITS)*CLK_DIV cycles. With CLK_DIV=2, N_BITS=64 this is 261 cycles.
- Accept-to-accept throughput for back-to-back requests: rsp latency + CLK_DIV + 1 cycles. With CLK_DIV=2 this is 264.
- Address boundary: the address goes out unmodified. Wrap at 24'hFFFFFF is the flash's responsibility. Any byte offset is legal.
- spi_miso is sampled directly with no synchroniser; it is assumed synchronous to the SCK timing.

Optional Feature:
- Macro SPI_FLASH_FAST_READ_EN.
- Defined:
  - Command byte is 8'h0B.
  - 8 dummy SCK periods are inserted after the address, with spi_mosi=0 and miso ignored.
  - N_BITS=72.
  - Latency with CLK_DIV=2 is 293 cycles.
- Undefined: command 8'h03, N_BITS=64, no dummy periods.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles, then release -> spi_cs_n=1, spi_sck=0, rsp_valid=0 throughout reset; req_ready=1 on the first cycle after release.
- Single read, CLK_DIV=2, flash bytes 0x000100..0x000103 = 11,22,33,44, req_addr=24'h000100:
  - Bus response: rsp_valid pulses exactly 261 cycles after accept with rsp_data=32'h44332211.
  - SPI waveform: exactly 64 SCK rising edges while cs_n is low; MOSI bits decode to 0x03,0x00,0x01,0x00.
- Unaligned read at 24'h000101 -> rsp_data=32'h55443322 (with byte 0x000104=55).
- Back-to-back: req_valid held high for 3 requests at 0x0, 0x4, 0x8 -> 3 rsp_valid pulses 264 cycles apart with correct words; cs_n high for >=2 cycles between transactions.
- Reset mid-transaction: drive rst_n=0 at bit 40 of SHIFT -> next cycle spi_cs_n=1, spi_sck=0, no rsp_valid; the following request completes normally.
- With SPI_FLASH_FAST_READ_EN, addr 24'h000100 -> command byte 0x0B, 72 SCK edges, rsp_valid 293 cycles after accept, rsp_data=32'h44332211.
